// File: rtl/riscv_inst_encoder_pkg.sv
// rtl/riscv_inst_encoder_pkg.sv - shared core types for RISC-V instruction encoding
//
// Contents: InstFormat and OpCode enums, one packed struct per format
// (R/I/S/B/U/J), the Instruction union that overlays them, the NOP constant,
// and the output FIFO occupancy state and entry types.
package riscv_inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } inst_format_e;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_IMM    = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_instruction_t;

  typedef struct packed {
    logic [11:0] imm11_0;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_instruction_t;

  typedef struct packed {
    logic [6:0] imm11_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm4_0;
    logic [6:0] opcode;
  } s_instruction_t;

  typedef struct packed {
    logic       imm12;
    logic [5:0] imm10_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [3:0] imm4_1;
    logic       imm11;
    logic [6:0] opcode;
  } b_instruction_t;

  typedef struct packed {
    logic [19:0] imm31_12;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } u_instruction_t;

  typedef struct packed {
    logic       imm20;
    logic [9:0] imm10_1;
    logic       imm11;
    logic [7:0] imm19_12;
    logic [4:0] rd;
    logic [6:0] opcode;
  } j_instruction_t;

  typedef union packed {
    logic [31:0]    raw;
    r_instruction_t r;
    i_instruction_t i;
    s_instruction_t s;
    b_instruction_t b;
    u_instruction_t u;
    j_instruction_t j;
  } instruction_u;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Occupancy of the 2-entry output FIFO doubles as the control state.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } fifo_entry_t;

endpackage

// File: rtl/riscv_imm_packer.sv
// rtl/riscv_imm_packer.sv - combinational bit-field packer for R/I/S/B/U/J formats
//
// Ports: req_fmt/req_opcode/req_funct3/req_funct7/req_rd/req_rs1/req_rs2/req_imm
// in (instruction fields, imm in byte units, U imm pre-shifted by 12);
// instr/err out (encoded word, error flag).
// Macro RISCV_ENC_RANGE_CHECK_EN: flag immediates that do not fit their field;
// the truncated encoding is produced either way.
module riscv_imm_packer
  import riscv_inst_encoder_pkg::*;
(
  input  logic [2:0]  req_fmt,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic [31:0] instr,
  output logic        err
);

  instruction_u word;
  logic         range_err;

`ifdef RISCV_ENC_RANGE_CHECK_EN
  // Value fits in a signed field of width w when all bits from w-1 upward
  // are copies of the sign bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
    logic [31:0] s;
    s = $signed(v) >>> (w - 1);
    return (s == 32'h0) || (s == 32'hFFFF_FFFF);
  endfunction

  always_comb begin
    range_err = 1'b0;
    case (req_fmt)
      FMT_I, FMT_S: range_err = !fits_signed(req_imm, 12);
      FMT_B:        range_err = !fits_signed(req_imm, 13) || req_imm[0];
      FMT_J:        range_err = !fits_signed(req_imm, 21) || req_imm[0];
      FMT_U:        range_err = (req_imm[11:0] != 12'h000);
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  always_comb begin
    word.raw = NOP_INSTR;
    err      = 1'b0;
    case (req_fmt)
      FMT_R: word.r = '{funct7: req_funct7, rs2: req_rs2, rs1: req_rs1,
                        funct3: req_funct3, rd: req_rd, opcode: req_opcode};
      FMT_I: word.i = '{imm11_0: req_imm[11:0], rs1: req_rs1,
                        funct3: req_funct3, rd: req_rd, opcode: req_opcode};
      FMT_S: word.s = '{imm11_5: req_imm[11:5], rs2: req_rs2, rs1: req_rs1,
                        funct3: req_funct3, imm4_0: req_imm[4:0], opcode: req_opcode};
      FMT_B: word.b = '{imm12: req_imm[12], imm10_5: req_imm[10:5], rs2: req_rs2,
                        rs1: req_rs1, funct3: req_funct3, imm4_1: req_imm[4:1],
                        imm11: req_imm[11], opcode: req_opcode};
      FMT_U: word.u = '{imm31_12: req_imm[31:12], rd: req_rd, opcode: req_opcode};
      FMT_J: word.j = '{imm20: req_imm[20], imm10_1: req_imm[10:1], imm11: req_imm[11],
                        imm19_12: req_imm[19:12], rd: req_rd, opcode: req_opcode};
      default: begin
        word.raw = NOP_INSTR;
        err      = 1'b1;
      end
    endcase
    if (range_err) err = 1'b1;
  end

  assign instr = word.raw;

endmodule

// File: rtl/riscv_inst_encoder.sv
// rtl/riscv_inst_encoder.sv - RISC-V instruction encoder with 2-entry output FIFO
//
// Ports: clk, rst_n (async, active-low);
// request side req_valid/req_ready plus req_fmt, req_opcode, req_funct3,
// req_funct7, req_rd, req_rs1, req_rs2, req_imm;
// output side out_valid/out_ready, out_instr, out_err;
// enc_count = words taken by the consumer (wraps at 16 bits).
// Macro RISCV_ENC_RANGE_CHECK_EN: enables immediate range checking in the packer.
module riscv_inst_encoder
  import riscv_inst_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fmt,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count
);

  occ_state_e  state_q, state_d;
  fifo_entry_t mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic        push, pop;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic [15:0] enc_count_q;

  riscv_imm_packer u_packer (
    .req_fmt    (req_fmt),
    .req_opcode (req_opcode),
    .req_funct3 (req_funct3),
    .req_funct7 (req_funct7),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .instr      (enc_instr),
    .err        (enc_err)
  );

  // Ready depends only on registered occupancy (never on out_ready); rst_n
  // gates it so nothing is accepted while reset is held.
  assign req_ready = rst_n && (state_q != OCC_FULL);
  assign out_valid = (state_q != OCC_EMPTY);
  assign push      = req_valid && req_ready;
  assign pop       = out_valid && out_ready;

  // The head entry is never the write target while non-empty, so the output
  // stays stable under backpressure.
  assign out_instr = mem_q[rd_ptr_q].instr;
  assign out_err   = mem_q[rd_ptr_q].err;
  assign enc_count = enc_count_q;

  always_comb begin
    state_d = state_q;
    case ({push, pop})
      2'b10: begin
        case (state_q)
          OCC_EMPTY: state_d = OCC_ONE;
          OCC_ONE:   state_d = OCC_FULL;
          default:   state_d = OCC_FULL;
        endcase
      end
      2'b01: begin
        case (state_q)
          OCC_FULL: state_d = OCC_ONE;
          OCC_ONE:  state_d = OCC_EMPTY;
          default:  state_d = OCC_EMPTY;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OCC_EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      enc_count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem_q[wr_ptr_q] <= '{instr: enc_instr, err: enc_err};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q    <= ~rd_ptr_q;
        enc_count_q <= enc_count_q + 16'd1;
      end
    end
  end

endmodule

// File: doc/riscv_inst_encoder.md
RISCV_INST_ENCODER -- requirements
Module: riscv_inst_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port req_valid, input, 1 bit: field request present.
REQ-004 SHALL have port req_ready, output, 1 bit: encoder accepts a request this cycle.
REQ-005 SHALL have port req_fmt, input, 3 bits: InstFormat enum value (R, I, S, B, U, J).
REQ-006 SHALL have port req_opcode, input, 7 bits: OpCode enum value.
REQ-007 SHALL have ports req_funct3, req_funct7, req_rd, req_rs1 and req_rs2, all inputs, widths 3/7/5/5/5 bits: instruction fields.
REQ-008 SHALL have port req_imm, input, 32 bits: signed immediate in byte units; for U format it is the upper-20 value already shifted left by 12.
REQ-009 SHALL have port out_valid, output, 1 bit: encoded word available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the word.
REQ-011 SHALL have port out_instr, output, 32 bits: encoded instruction.
REQ-012 SHALL have port out_err, output, 1 bit: error flag travelling with out_instr.
REQ-013 SHALL have port enc_count, output, 16 bits: number of words accepted by the consumer.

Function
REQ-014 SHALL accept a request on a cycle where req_valid and req_ready are both high.
REQ-015 SHALL encode the accepted request combinationally and write it into a 2-entry output FIFO holding out_instr and out_err.
REQ-016 SHALL present the word on out_valid/out_instr the cycle after acceptance when the FIFO was empty, giving 1-cycle latency.
REQ-017 SHALL drive req_ready = (FIFO occupancy < 2), with no combinational path from out_ready.
REQ-018 SHALL pop the FIFO head on a cycle where out_valid and out_ready are both high.
REQ-019 SHALL, on a simultaneous push and pop, leave occupancy unchanged and keep order; at occupancy 2 a push SHALL be impossible because req_ready is 0.
REQ-020 SHALL use FIFO occupancy as the state (EMPTY, ONE, FULL), with transitions +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-021 SHALL hold out_valid, out_instr and out_err stable while out_valid is high and out_ready is low.
REQ-022 SHALL place bit fields per format:
 - R: funct7|rs2|rs1|funct3|rd|opcode.
 - I: imm[11:0]|rs1|funct3|rd|opcode.
 - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
 - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
 - U: imm[31:12]|rd|opcode.
 - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-023 SHALL encode an undefined req_fmt as 0x00000013 (NOP) with out_err=1.
REQ-024 SHALL increment enc_count on each pop, wrapping from 0xFFFF to 0x0000.

Reset
REQ-025 SHALL, while rst_n is low, immediately force FIFO occupancy to 0, out_valid=0, out_instr=0, out_err=0, enc_count=0 and req_ready=0.
REQ-026 SHALL assert req_ready in the first clk edge after rst_n deasserts; entries in flight at reset SHALL be discarded.

Configuration
REQ-027 SHALL, with macro RISCV_ENC_RANGE_CHECK_EN defined, set out_err=1 for any of: I/S imm outside -2048..2047; B imm outside -4096..4094 or odd; J imm outside -2^20..2^20-2 or odd; U imm[11:0] nonzero. Fields SHALL still be truncated and encoded.
REQ-028 SHALL, without RISCV_ENC_RANGE_CHECK_EN, truncate silently and set out_err only for an undefined req_fmt.

Structure
REQ-029 SHALL add to the shared core package: the InstFormat enum (R=0, I=1, S=2, B=3, U=4, J=5), UInstruction and JInstruction packed structs, their members in the Instruction union, and the NOP constant.
REQ-030 SHALL place the combinational field packing in one sub-module, riscv_imm_packer, so that the top level holds the FIFO, handshake and counter.

Verification
REQ-031 SHALL check: I, opcode IMM, rd=1, rs1=0, funct3=0, imm=5 -> 0x00500093 one cycle later, out_err=0.
REQ-032 SHALL check: R, opcode OP, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> 0x002081B3.
REQ-033 SHALL check: S, funct3=010, rs1=1, rs2=2, imm=8 -> 0x0020A423; B, rs1=rs2=0, funct3=0, imm=-4 -> 0xFE000EE3.
REQ-034 SHALL check: out_ready=0 while issuing three requests -> req_ready drops after two; then out_ready=1 -> words emerge in order and enc_count=2.
REQ-035 SHALL check, with the macro defined: I imm=2048 -> out_err=1; B imm=3 -> out_err=1; without the macro both -> out_err=0.
REQ-036 SHALL check: rst_n pulsed low with FIFO FULL -> out_valid=0 and enc_count=0 at once; one request after release -> single correct word out.
